// File: rtl/spi_tx_fifo_pkg.sv
// Shared types and helpers for the SPI TX FIFO.
// Sticky error flag bundle and its next-state rule.
`include "spi_tx_defines.vh"
package spi_tx_fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH   = `DATA_WIDTH;
   localparam int unsigned DEF_DEPTH_LOG2   = `FIFO_DEPTH_LOG2;
   localparam int unsigned DEF_AFULL_THRESH = `FIFO_AFULL_THRESH;

   typedef struct packed {
      logic ovf;
      logic udf;
   } err_flags_t;

   // A new event in the same cycle as a clear keeps the flag set.
   function automatic logic sticky_next(
      input logic q,
      input logic clr,
      input logic ev
   );
      return ev | (q & ~clr);
   endfunction

endpackage

// File: rtl/spi_tx_defines.vh
// Shared SPI TX configuration macros.
// Word width plus FIFO depth and almost-full threshold defaults.
`ifndef SPI_TX_DEFINES_VH
`define SPI_TX_DEFINES_VH
`define DATA_WIDTH 32
`define FIFO_DEPTH_LOG2 4
`define FIFO_AFULL_THRESH 14
`endif

// File: rtl/spi_tx_fifo_mem.sv
// Register-array storage for the SPI TX FIFO.
// Ports: clk_i, we_i, waddr_i, wdata_i (sync write); raddr_i -> rdata_o (async read).
module spi_tx_fifo_mem #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_tx_fifo.sv
// First-word-fall-through transmit FIFO feeding the SPI TX controller.
// Ports: CLK/RST_N, clear, err_clr, push side (write/data_in/full/afull),
// pop side (read/empty/data_out), fifo_tx_level, sticky overflow/underflow.
`include "spi_tx_defines.vh"
module spi_tx_fifo
   import spi_tx_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = `DATA_WIDTH,
   parameter int unsigned DEPTH_LOG2   = `FIFO_DEPTH_LOG2,
   parameter int unsigned AFULL_THRESH = `FIFO_AFULL_THRESH
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  clear,
   input  logic                  err_clr,
   input  logic                  fifo_tx_write,
   input  logic [DATA_WIDTH-1:0] fifo_tx_data_in,
   output logic                  fifo_tx_full,
   output logic                  fifo_tx_afull,
   input  logic                  fifo_tx_read,
   output logic                  fifo_tx_empty,
   output logic [DATA_WIDTH-1:0] fifo_tx_data_out,
   output logic [DEPTH_LOG2:0]   fifo_tx_level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
   err_flags_t            err_q, err_d;
   logic                  push, pop;
   logic                  ovf_ev, udf_ev;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Extra pointer MSB distinguishes full from empty when low bits match.
   assign fifo_tx_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_tx_full  =
      (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
      (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
   assign fifo_tx_level = wr_ptr_q - rd_ptr_q;
   assign fifo_tx_afull = 32'(fifo_tx_level) >= AFULL_THRESH;

   // A pop on a full FIFO frees the slot this same push lands in.
   assign pop    = fifo_tx_read && !fifo_tx_empty;
   assign push   = fifo_tx_write && (!fifo_tx_full || fifo_tx_read);
   assign ovf_ev = fifo_tx_write && fifo_tx_full && !fifo_tx_read;
   assign udf_ev = fifo_tx_read && fifo_tx_empty;
   assign mem_we = push && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      err_d.ovf = sticky_next(err_q.ovf, err_clr, ovf_ev);
      err_d.udf = sticky_next(err_q.udf, err_clr, udf_ev);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   spi_tx_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_LOG2)
   ) u_mem (
      .clk_i   (CLK),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
      .wdata_i (fifo_tx_data_in),
      .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
      .rdata_o (mem_rdata)
   );

   // Memory is not reset, so mask stale contents while empty.
   assign fifo_tx_data_out = fifo_tx_empty ? '0 : mem_rdata;
   assign overflow         = err_q.ovf;
   assign underflow        = err_q.udf;

endmodule
